// File: rtl/opb_reg_bank_pkg.sv
// rtl/opb_reg_bank_pkg.sv - shared types and OPB bit-mapping helpers for the register bank
package opb_reg_bank_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {IDLE, ACK, HOLD} ack_state_t;

  // OPB numbers bits MSB-first: opb[i] carries user bit WORD_W-1-i.
  function automatic logic [WORD_W-1:0] opb_to_user(input logic [0:WORD_W-1] v);
    logic [WORD_W-1:0] r;
    for (int i = 0; i < WORD_W; i++) r[WORD_W-1-i] = v[i];
    return r;
  endfunction

  function automatic logic [0:WORD_W-1] user_to_opb(input logic [WORD_W-1:0] v);
    logic [0:WORD_W-1] r;
    for (int i = 0; i < WORD_W; i++) r[i] = v[WORD_W-1-i];
    return r;
  endfunction

  // be[0] selects the most significant user byte.
  function automatic logic [WORD_W-1:0] be_merge(input logic [WORD_W-1:0] old_val,
                                                 input logic [WORD_W-1:0] new_val,
                                                 input logic [0:3]        be);
    logic [WORD_W-1:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[WORD_W-1-8*b -: 8] = new_val[WORD_W-1-8*b -: 8];
    return r;
  endfunction

endpackage

// File: rtl/opb_register_bank_ppc2simulink_if.sv
// rtl/opb_register_bank_ppc2simulink_if.sv - OPB slave-side bus signals with master/slave views
interface opb_register_bank_ppc2simulink_if;
  import opb_reg_bank_pkg::*;

  logic [0:WORD_W-1] OPB_ABus;
  logic [0:3]        OPB_BE;
  logic [0:WORD_W-1] OPB_DBus;
  logic              OPB_RNW;
  logic              OPB_select;
  logic              OPB_seqAddr;
  logic [0:WORD_W-1] Sl_DBus;
  logic              Sl_errAck;
  logic              Sl_retry;
  logic              Sl_toutSup;
  logic              Sl_xferAck;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );

endinterface

// File: rtl/opb_slave_ack_fsm.sv
// rtl/opb_slave_ack_fsm.sv - address hit/index decode and single-ack IDLE/ACK/HOLD sequencing
module opb_slave_ack_fsm
  import opb_reg_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h01014200,
  parameter logic [31:0] C_HIGHADDR = 32'h010142FF,
  parameter int          AW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [0:31]   abus,
  input  logic          select,
  input  logic          rnw,
  output logic          ack,
  output logic          rd_en,
  output logic          wr_en,
  output logic [AW-1:0] idx
);

  ack_state_t  state, state_nxt;
  logic        hit;
  logic        rnw_q;
  logic [31:0] addr;
  logic [31:0] offset;

  assign addr   = abus;
  assign hit    = select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign offset = addr - C_BASEADDR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      rnw_q <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == IDLE && hit) begin
        idx   <= AW'(offset >> 2);
        rnw_q <= rnw;
      end
    end
  end

  // HOLD waits for select to drop so a long-held select is acked only once.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hit) state_nxt = ACK;
      ACK:     state_nxt = HOLD;
      HOLD:    if (!select) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ack   = (state == ACK) && !rst;
  assign rd_en = ack && rnw_q;
  assign wr_en = ack && !rnw_q;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// rtl/opb_register_bank_ppc2simulink.sv - N_REGS PPC read/write registers with fabric outputs; OPB_REG_BANK_COMMIT_EN adds shadow/commit
module opb_register_bank_ppc2simulink
  import opb_reg_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01014200,
  parameter logic [31:0] C_HIGHADDR   = 32'h010142FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          N_REGS       = 4,
  parameter logic [31:0] RESET_VALUE  = 32'h00000000
) (
  input  logic                         OPB_Clk,
  input  logic                         OPB_Rst,
  opb_register_bank_ppc2simulink_if.slave bus,
  output logic [N_REGS*WORD_W-1:0]     user_data_out,
  output logic [N_REGS-1:0]            user_wr_strb,
  input  logic                         commit_in
);

  logic                    ack, rd_en, wr_en;
  logic [C_OPB_AWIDTH-1:0] idx;
  logic [WORD_W-1:0]       wdata;
  logic [C_OPB_DWIDTH-1:0] rd_word;
  logic [N_REGS-1:0]       wr_hit;
  logic [WORD_W-1:0]       bus_regs [N_REGS];
  logic [WORD_W-1:0]       out_regs [N_REGS];
  logic                    unused_inputs;

  opb_slave_ack_fsm #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR),
    .AW         (C_OPB_AWIDTH)
  ) u_ack_fsm (
    .clk    (OPB_Clk),
    .rst    (OPB_Rst),
    .abus   (bus.OPB_ABus),
    .select (bus.OPB_select),
    .rnw    (bus.OPB_RNW),
    .ack    (ack),
    .rd_en  (rd_en),
    .wr_en  (wr_en),
    .idx    (idx)
  );

  assign wdata = opb_to_user(bus.OPB_DBus);

  // In-window indices past the bank match nothing: writes vanish, reads give 0.
  always_comb begin
    wr_hit  = '0;
    rd_word = '0;
    for (int r = 0; r < N_REGS; r++) begin
      if (wr_en && idx == C_OPB_AWIDTH'(r)) wr_hit[r] = 1'b1;
      if (idx == C_OPB_AWIDTH'(r)) rd_word = bus_regs[r];
    end
  end

  assign bus.Sl_DBus    = rd_en ? user_to_opb(rd_word) : '0;
  assign bus.Sl_xferAck = ack;
  assign bus.Sl_errAck  = 1'b0;
  assign bus.Sl_retry   = 1'b0;
  assign bus.Sl_toutSup = 1'b0;

`ifdef OPB_REG_BANK_COMMIT_EN
  logic [N_REGS-1:0] dirty;
  logic              commit;

  assign commit = commit_in || (wr_en && idx == C_OPB_AWIDTH'(N_REGS));

  // Commit samples the shadows before this cycle's write lands.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int r = 0; r < N_REGS; r++) begin
        bus_regs[r] <= RESET_VALUE;
        out_regs[r] <= RESET_VALUE;
      end
      dirty        <= '0;
      user_wr_strb <= '0;
    end else begin
      for (int r = 0; r < N_REGS; r++) begin
        if (wr_hit[r]) bus_regs[r] <= be_merge(bus_regs[r], wdata, bus.OPB_BE);
        if (commit) out_regs[r] <= bus_regs[r];
      end
      user_wr_strb <= commit ? dirty : '0;
      dirty        <= commit ? wr_hit : (dirty | wr_hit);
    end
  end

  assign unused_inputs = bus.OPB_seqAddr;
`else
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int r = 0; r < N_REGS; r++) bus_regs[r] <= RESET_VALUE;
      user_wr_strb <= '0;
    end else begin
      for (int r = 0; r < N_REGS; r++)
        if (wr_hit[r]) bus_regs[r] <= be_merge(bus_regs[r], wdata, bus.OPB_BE);
      user_wr_strb <= wr_hit;
    end
  end

  assign out_regs      = bus_regs;
  assign unused_inputs = ^{bus.OPB_seqAddr, commit_in};
`endif

  for (genvar g = 0; g < N_REGS; g++) begin : g_out
    assign user_data_out[g*WORD_W +: WORD_W] = out_regs[g];
  end

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// tb/tb_opb_register_bank_ppc2simulink.sv - scoreboard bench with a behavioural register-bank model
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h01014200;
  localparam logic [31:0] HIGH = 32'h010142FF;
  localparam int          N    = 4;
`ifdef OPB_REG_BANK_COMMIT_EN
  localparam bit CM = 1'b1;
`else
  localparam bit CM = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0]    s;
    logic [N*32-1:0] d;
  } strb_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            commit_in;
  logic [N*32-1:0] udo;
  logic [N-1:0]    strb;
  int              total = 0;
  int              bad = 0;

  logic [31:0]     shadow [N];
  logic [31:0]     outm [N];
  logic [N-1:0]    dirty;
  logic [31:0]     ack_q [$];
  strb_t           strb_q [$];

  opb_register_bank_ppc2simulink_if bus ();

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR (BASE),
    .C_HIGHADDR (HIGH),
    .N_REGS     (N)
  ) dut (
    .OPB_Clk       (clk),
    .OPB_Rst       (rst),
    .bus           (bus),
    .user_data_out (udo),
    .user_wr_strb  (strb),
    .commit_in     (commit_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N*32-1:0] act, input logic [N*32-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [N*32-1:0] out_vec();
    logic [N*32-1:0] v;
    for (int r = 0; r < N; r++) v[r*32 +: 32] = outm[r];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < N; r++) begin
      shadow[r] = 32'h0;
      outm[r]   = 32'h0;
    end
    dirty = '0;
  endtask

  task automatic model_commit();
    for (int r = 0; r < N; r++) outm[r] = shadow[r];
    if (dirty != '0) strb_q.push_back({dirty, out_vec()});
    dirty = '0;
  endtask

  task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] be);
    logic [31:0]  mask;
    logic [N-1:0] one;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    shadow[idx] = (shadow[idx] & ~mask) | (data & mask);
    one = 1;
    if (CM) dirty[idx] = 1'b1;
    else begin
      outm[idx] = shadow[idx];
      strb_q.push_back({one << idx, out_vec()});
    end
  endtask

  // Expectations are queued first, then the bus beat is driven.
  task automatic access(input logic [31:0] addr, input logic rnw, input logic [31:0] data,
                        input logic [3:0] be, input int hold, input logic cflag);
    logic in_win;
    int   idx;
    in_win = (addr >= BASE) && (addr <= HIGH);
    idx    = int'((addr - BASE) >> 2);
    if (in_win) ack_q.push_back((rnw && idx < N) ? shadow[idx] : 32'h0);
    if (CM && (cflag || (in_win && !rnw && idx == N))) model_commit();
    if (in_win && !rnw && idx < N) model_write(idx, data, be);
    @(posedge clk); #1;
    bus.OPB_ABus   = addr;
    bus.OPB_RNW    = rnw;
    bus.OPB_DBus   = data;
    bus.OPB_BE     = be;
    bus.OPB_select = 1'b1;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      commit_in = cflag && (c == 0);
    end
    commit_in      = 1'b0;
    bus.OPB_select = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic commit_pulse();
    @(posedge clk); #1;
    commit_in = 1'b1;
    model_commit();
    @(posedge clk); #1;
    commit_in = 1'b0;
  endtask

  logic [31:0] mon_dbus;
  strb_t       mon_e;

  always @(negedge clk) begin
    mon_dbus = bus.Sl_DBus;
    if (bus.Sl_xferAck === 1'b1) begin
      if (ack_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got ack want none");
      end else chk("ack_dbus", mon_dbus, ack_q.pop_front());
    end else chk("idle_dbus_zero", mon_dbus, '0);
    if (strb !== '0) begin
      if (strb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got %b want none", strb);
      end else begin
        mon_e = strb_q.pop_front();
        chk("wr_strb", strb, mon_e.s);
        chk("strobe_data", udo, mon_e.d);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          sel;
    rst             = 1'b1;
    commit_in       = 1'b0;
    bus.OPB_ABus    = '0;
    bus.OPB_BE      = '0;
    bus.OPB_DBus    = '0;
    bus.OPB_RNW     = 1'b0;
    bus.OPB_select  = 1'b0;
    bus.OPB_seqAddr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_udo", udo, '0);
    chk("reset_strb", strb, '0);
    chk("reset_ack", bus.Sl_xferAck, '0);
    chk("tied_outputs", {bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, '0);
    rst = 1'b0;

    for (int i = 0; i < N; i++) access(BASE + 32'(i * 4), 1'b1, 32'h0, 4'hF, 2, 1'b0);
    access(BASE + 32'd4, 1'b0, 32'hDEADBEEF, 4'b1111, 2, 1'b0);
    access(BASE + 32'd4, 1'b1, 32'h0, 4'hF, 2, 1'b0);
    access(BASE + 32'd4, 1'b0, 32'h11223344, 4'b0100, 2, 1'b0);
    access(BASE + 32'd4, 1'b1, 32'h0, 4'hF, 2, 1'b0);
    access(BASE + 32'h80, 1'b1, 32'h0, 4'hF, 2, 1'b0);
    access(BASE + 32'h80, 1'b0, 32'hFFFFFFFF, 4'hF, 2, 1'b0);
    access(BASE + 32'd8, 0, 32'hCAFE0001, 4'hF, 5, 1'b0);
    access(BASE + 32'd12, 1'b0, 32'h55555555, 4'b0000, 2, 1'b0);
    access(BASE - 32'd4, 1'b0, 32'h12345678, 4'hF, 2, 1'b0);
    chk("after_directed_udo", udo, out_vec());

    @(posedge clk); #1;
    bus.OPB_ABus   = BASE;
    bus.OPB_RNW    = 1'b0;
    bus.OPB_DBus   = 32'h12345678;
    bus.OPB_BE     = 4'hF;
    bus.OPB_select = 1'b1;
    @(posedge clk); #1;
    rst            = 1'b1;
    bus.OPB_select = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("rst_in_ack_udo", udo, '0);
    chk("rst_in_ack_strb", strb, '0);

`ifdef OPB_REG_BANK_COMMIT_EN
    access(BASE + 32'd4, 1'b0, 32'd5, 4'hF, 2, 1'b0);
    chk("commit_pending", udo, out_vec());
    commit_pulse();
    chk("commit_applied", udo, out_vec());
    access(BASE + 32'd8, 1'b0, 32'd7, 4'hF, 2, 1'b1);
    chk("write_with_commit", udo, out_vec());
    commit_pulse();
    chk("second_commit", udo, out_vec());
    access(BASE + 32'd4, 1'b0, 32'h99, 4'hF, 2, 1'b0);
    access(BASE + 32'(N * 4), 1'b0, 32'h0, 4'hF, 2, 1'b0);
    chk("commit_addr", udo, out_vec());
`endif

    for (int n = 0; n < 150; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 8) a = BASE + 32'((sel % (N + 2)) * 4) + 32'($urandom_range(0, 3));
      else if (sel == 8) a = BASE + 32'h80 + 32'($urandom_range(0, 3));
      else a = ($urandom_range(0, 1) == 1) ? BASE - 32'd4 : HIGH + 32'd1;
      access(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
             int'($urandom_range(2, 5)), $urandom_range(0, 7) == 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("final_udo", udo, out_vec());
    chk("pending_acks", ack_q.size(), '0);
    chk("pending_strobes", strb_q.size(), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
- Parametrised successor of the single OPB software register: a bank of N_REGS 32-bit PPC-writable and PPC-readable registers in one address window.
- Each register drives fabric-side outputs and emits a one-cycle write strobe.
- Byte-enable writes are supported, and out-of-range accesses are handled explicitly.
- Sits on the OPB bus between the PPC and user (Simulink) logic.
- All logic runs on the single bus clock.

Parameters:
- C_BASEADDR, 32'h01014200, first byte address of the window.
- C_HIGHADDR, 32'h010142FF, last byte address of the window.
- C_OPB_AWIDTH, 32, address bus width.
- C_OPB_DWIDTH, 32, data bus width; only 32 is supported.
- N_REGS, 4, number of registers, range 1..32; must satisfy N_REGS*4 <= window size.
- RESET_VALUE, 32'h00000000, reset value of every register.

Ports:
- OPB_Clk  in  1  sole clock for bus and user side.
- OPB_Rst  in  1  synchronous, active-high reset.
- OPB_ABus  in  [0:31]  address.
- OPB_BE  in  [0:3]  byte enables; BE[0] = OPB_DBus[0:7] = user bits 31:24.
- OPB_DBus  in  [0:31]  write data; OPB_DBus[i] maps to user bit 31-i.
- OPB_RNW  in  1  1 = read.
- OPB_select  in  1  master select.
- OPB_seqAddr  in  1  ignored; each beat is acked individually.
- Sl_DBus  out  [0:31]  read data; zero when not acking.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- user_data_out  out  [N_REGS*32-1:0]  register r occupies bits [32r+31:32r].
- user_wr_strb  out  [N_REGS-1:0]  one-cycle pulse on the cycle register r updates.
- commit_in  in  1  commit pulse; used only with the optional feature, ignored otherwise.

Behaviour:
- Reset (synchronous, active-high on OPB_Clk):
  - Every register = RESET_VALUE.
  - Sl_DBus = 0, Sl_xferAck = 0, user_wr_strb = 0, FSM = IDLE.
- Hit = OPB_select & (C_BASEADDR <= OPB_ABus <= C_HIGHADDR).
- idx = (OPB_ABus - C_BASEADDR) >> 2; low two address bits are ignored.
- FSM states:
  - IDLE -> ACK on hit.
  - ACK lasts exactly one cycle and asserts Sl_xferAck -> HOLD.
  - HOLD -> IDLE when OPB_select = 0, otherwise stays in HOLD. HOLD prevents double-acking a held select.
- Latency: hit sampled at edge k; Sl_xferAck high for cycle k+1.
- Write (RNW=0), idx < N_REGS:
  - Each byte lane b with BE[b]=1 is loaded at the end of the ACK cycle.
  - Lanes with BE=0 are unchanged.
  - user_wr_strb[idx] is high during cycle k+2, aligned with the new user_data_out value.
  - A write with BE=0000 is still acked, and the strobe still fires.
- Read (RNW=1): Sl_DBus = reg[idx] (bit-reversed mapping) during the ACK cycle only; 0 in all other cycles (OR-bus requirement).
- idx >= N_REGS but inside the window:
  - Write is discarded with no strobe.
  - Read returns 0.
  - Ack is still given.
- Reset asserted in ACK or HOLD: reset wins; no ack that cycle; any register update in flight is lost.
- Back-to-back: a new access is accepted only after select drops, so the minimum is 3 cycles per transfer.

Optional Feature:
- Macro OPB_REG_BANK_COMMIT_EN.
- Defined:
  - Bus writes land in shadow registers; reads return shadow values.
  - user_data_out copies all shadows atomically at the end of any cycle with commit_in=1, or on a write to index N_REGS (commit address). Commit-address reads return 0.
  - user_wr_strb[r] pulses on the commit cycle for each r whose shadow was written since the last commit.
  - Write and commit in the same cycle: the commit copies the pre-write shadow; the new value awaits the next commit.
- Undefined: no shadow registers; commit_in is ignored; index N_REGS is treated as out-of-range.

Decomposition:
- Package opb_reg_bank_pkg:
  - WORD_W = 32.
  - FSM state enum {IDLE, ACK, HOLD}.
  - Function for byte-lane merge with the BE[0]-is-MSB mapping.
  - Function for OPB/user bit-reversal.
- One sub-module, opb_slave_ack_fsm: address hit, idx decode, IDLE/ACK/HOLD sequencing, and ack/read-enable/write-enable outputs.
- The top holds the register array and the strobes.

Test Plan:
- Reset, then read idx 0..3 -> Sl_DBus = 32'h00000000 each; Sl_xferAck exactly 1 cycle per access.
- Write 32'hDEADBEEF to 0x01014204 with BE=1111 -> user_data_out[63:32] = DEADBEEF at cycle k+2; user_wr_strb = 4'b0010 for 1 cycle; readback = DEADBEEF.
- Then write 32'h11223344 to 0x01014204 with BE=0100 -> register = DE22BEEF.
- Read 0x01014280 (idx 32) -> ack given, Sl_DBus = 0. Write to the same address -> no strobe, no register change.
- Hold OPB_select high for 5 cycles on one access -> exactly one Sl_xferAck and one strobe. Assert OPB_Rst during the ACK cycle -> no ack, all registers = RESET_VALUE.
- With OPB_REG_BANK_COMMIT_EN: write idx 1 = 5, user_data_out unchanged. Pulse commit_in -> next cycle user_data_out[63:32] = 5 and user_wr_strb = 0010. Write idx 2 = 7 in the same cycle as commit_in -> idx 2 output unchanged until the next commit.
